apb_master: RTL and testbench

APB requester that turns single-word read/write commands from an on-chip front end into APB transfers to the POLI register slave or any other APB completer. Runs the IDLE/SETUP/ACCESS phases, honours PREADY wait states, supports back-to-back transfers, aborts on a programmable wait-state timeout and returns one response per command.

---
 rtl/apb_master.sv | 115 +++++++++++
 tb/tb_apb_master.sv | 465 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/apb_master.sv
// APB requester: turns single-word read/write commands into APB SETUP/ACCESS
// transfers, with PREADY wait states, back-to-back issue and a wait-state timeout.
module apb_master #(
  parameter int ADDR_WIDTH     = 32,
  parameter int DATA_WIDTH     = 32,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic                  CLK,
  input  logic                  nRST,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic                  cmd_write,
  input  logic [ADDR_WIDTH-1:0] cmd_addr,
  input  logic [DATA_WIDTH-1:0] cmd_wdata,
  output logic                  rsp_valid,
  output logic [DATA_WIDTH-1:0] rsp_rdata,
  output logic                  rsp_err,
  output logic                  rsp_timeout,
  output logic                  PSEL,
  output logic                  PENABLE,
  output logic                  PWRITE,
  output logic [ADDR_WIDTH-1:0] PADDR,
  output logic [DATA_WIDTH-1:0] PWDATA,
  input  logic [DATA_WIDTH-1:0] PRDATA,
  input  logic                  PREADY,
  input  logic                  PSLVERR
);

  typedef enum logic [1:0] {IDLE, SETUP, ACCESS} state_t;

  localparam int CW = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam logic [CW-1:0] T_LIM = CW'(TIMEOUT_CYCLES);

  state_t        state;
  logic [CW-1:0] wait_cnt;
  logic [CW-1:0] wait_inc;
  logic          accept;
  logic          timeout_hit;

  assign cmd_ready   = nRST & ((state == IDLE) | ((state == ACCESS) & PREADY));
  assign accept      = cmd_valid & cmd_ready;
  assign wait_inc    = (wait_cnt == '1) ? wait_cnt : wait_cnt + CW'(1);
  assign timeout_hit = (TIMEOUT_CYCLES != 0) && (wait_inc == T_LIM);

  // PADDR/PWRITE/PWDATA double as the command register: loaded on accept and
  // held unchanged through SETUP and ACCESS.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state       <= IDLE;
      wait_cnt    <= '0;
      PSEL        <= 1'b0;
      PENABLE     <= 1'b0;
      PWRITE      <= 1'b0;
      PADDR       <= '0;
      PWDATA      <= '0;
      rsp_valid   <= 1'b0;
      rsp_rdata   <= '0;
      rsp_err     <= 1'b0;
      rsp_timeout <= 1'b0;
    end else begin
      rsp_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (accept) begin
            PADDR    <= cmd_addr;
            PWRITE   <= cmd_write;
            PWDATA   <= cmd_write ? cmd_wdata : '0;
            wait_cnt <= '0;
            PSEL     <= 1'b1;
            state    <= SETUP;
          end
        end
        SETUP: begin
          PENABLE <= 1'b1;
          state   <= ACCESS;
        end
        ACCESS: begin
          if (PREADY) begin
            rsp_valid   <= 1'b1;
            rsp_rdata   <= PWRITE ? '0 : PRDATA;
            rsp_err     <= PSLVERR;
            rsp_timeout <= 1'b0;
            PENABLE     <= 1'b0;
            if (accept) begin
              PADDR    <= cmd_addr;
              PWRITE   <= cmd_write;
              PWDATA   <= cmd_write ? cmd_wdata : '0;
              wait_cnt <= '0;
              state    <= SETUP;
            end else begin
              PSEL  <= 1'b0;
              state <= IDLE;
            end
          end else if (timeout_hit) begin
            rsp_valid   <= 1'b1;
            rsp_rdata   <= '0;
            rsp_err     <= 1'b1;
            rsp_timeout <= 1'b1;
            PSEL        <= 1'b0;
            PENABLE     <= 1'b0;
            state       <= IDLE;
          end else begin
            wait_cnt <= wait_inc;
          end
        end
        default: begin
          PSEL    <= 1'b0;
          PENABLE <= 1'b0;
          state   <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_apb_master.sv
// Bench for apb_master: memory-backed APB completer with programmable waits and
// errors, response scoreboard, plus a second instance with the timeout disabled.
module tb_apb_master;

  logic        CLK = 1'b0;
  logic        nRST;
  logic        cmd_valid, cmd_ready, cmd_write;
  logic [31:0] cmd_addr, cmd_wdata;
  logic        rsp_valid, rsp_err, rsp_timeout;
  logic [31:0] rsp_rdata;
  logic        PSEL, PENABLE, PWRITE;
  logic [31:0] PADDR, PWDATA;
  logic [31:0] PRDATA = '0;
  logic        PREADY = 1'b0;
  logic        PSLVERR = 1'b0;

  logic        cmd_valid_nt, cmd_ready_nt;
  logic        rsp_valid_nt, rsp_err_nt, rsp_timeout_nt;
  logic [31:0] rsp_rdata_nt;
  logic        psel_nt, penable_nt, pwrite_nt;
  logic [31:0] paddr_nt, pwdata_nt;

  always #5 CLK = ~CLK;

  apb_master #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .TIMEOUT_CYCLES(16)) u_dut (
    .CLK(CLK), .nRST(nRST),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .rsp_timeout(rsp_timeout),
    .PSEL(PSEL), .PENABLE(PENABLE), .PWRITE(PWRITE), .PADDR(PADDR),
    .PWDATA(PWDATA), .PRDATA(PRDATA), .PREADY(PREADY), .PSLVERR(PSLVERR)
  );

  apb_master #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .TIMEOUT_CYCLES(0)) u_dut_nt (
    .CLK(CLK), .nRST(nRST),
    .cmd_valid(cmd_valid_nt), .cmd_ready(cmd_ready_nt), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
    .rsp_valid(rsp_valid_nt), .rsp_rdata(rsp_rdata_nt), .rsp_err(rsp_err_nt),
    .rsp_timeout(rsp_timeout_nt),
    .PSEL(psel_nt), .PENABLE(penable_nt), .PWRITE(pwrite_nt), .PADDR(paddr_nt),
    .PWDATA(pwdata_nt), .PRDATA(32'h1234_5678), .PREADY(1'b0), .PSLVERR(1'b0)
  );

  // Completer model: PREADY rises after n_wait low ACCESS cycles.
  logic [31:0] mem [16];
  int          n_wait = 0;
  bit          err_cfg = 0;
  bit          err_on_wait = 0;
  int          acc_cnt = 0;

  always @(negedge CLK) begin
    if (PSEL && PENABLE) begin
      PREADY  = (acc_cnt >= n_wait);
      acc_cnt = acc_cnt + 1;
      PRDATA  = PREADY ? mem[PADDR[5:2]] : 32'hBAD0_BAD0;
      PSLVERR = PREADY ? err_cfg : err_on_wait;
      if (PREADY && PWRITE) mem[PADDR[5:2]] = PWDATA;
    end else begin
      acc_cnt = 0;
      PREADY  = 1'b0;
      PSLVERR = err_on_wait;
      PRDATA  = 32'hBAD0_BAD0;
    end
  end

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    logic        tmo;
    int          lat;
    int          cyc;
  } rsp_t;

  rsp_t exp_q[$];
  rsp_t act_q[$];
  int   acc_q[$];
  rsp_t mon_r;
  int   cyc = 0;
  int   psel_gap = 0;
  bit   bb_mon = 0;
  int   checks = 0;
  int   failures = 0;

  always @(posedge CLK) cyc <= cyc + 1;

  // Monitor samples mid-low-phase; latency is counted from the accept cycle.
  always @(negedge CLK) begin
    #2;
    if (!nRST) begin
      acc_q.delete();
    end else begin
      if (cmd_valid && cmd_ready) acc_q.push_back(cyc);
      if (rsp_valid) begin
        mon_r.rdata = rsp_rdata;
        mon_r.err   = rsp_err;
        mon_r.tmo   = rsp_timeout;
        mon_r.cyc   = cyc;
        mon_r.lat   = (acc_q.size() > 0) ? cyc - acc_q.pop_front() : -1;
        act_q.push_back(mon_r);
      end
      if (bb_mon && !PSEL) psel_gap++;
    end
  end

  task automatic push_exp(input logic [31:0] rd, input logic e, input logic t, input int l);
    rsp_t r;
    r.rdata = rd; r.err = e; r.tmo = t; r.lat = l; r.cyc = 0;
    exp_q.push_back(r);
  endtask

  // Called at a falling edge; returns at the falling edge after the accepting edge.
  task automatic issue(input logic w, input logic [31:0] a, input logic [31:0] d);
    bit got = 0;
    cmd_valid = 1'b1; cmd_write = w; cmd_addr = a; cmd_wdata = d;
    for (int i = 0; i < 100 && !got; i++) begin
      #3;
      if (cmd_ready) got = 1;
      @(negedge CLK);
    end
    if (!got) begin
      checks++; failures++;
      $display("FAIL accept addr=%h: cmd_ready never seen within 100 cycles", a);
    end
  endtask

  task automatic wait_rsp(input int n);
    for (int i = 0; i < 300 && act_q.size() < n; i++) @(negedge CLK);
    #3;
    if (act_q.size() < n) begin
      checks++; failures++;
      $display("FAIL rsp_wait got=%0d want=%0d responses", act_q.size(), n);
    end
  endtask

  task automatic test_reset();
    #2;
    checks++;
    if ({PSEL, PENABLE, PWRITE, PADDR, PWDATA, rsp_valid, rsp_rdata, rsp_err, rsp_timeout, cmd_ready} !== '0) begin
      failures++;
      $display("FAIL reset_outputs psel=%b pen=%b paddr=%h rsp_v=%b cmd_ready=%b want all 0",
               PSEL, PENABLE, PADDR, rsp_valid, cmd_ready);
    end
    @(negedge CLK); @(negedge CLK);
    nRST = 1'b1;
    #3;
    checks++;
    if (cmd_ready !== 1'b1) begin
      failures++; $display("FAIL reset_release_ready got=%b want=1", cmd_ready);
    end
    @(negedge CLK);
    n_wait = 5;
    issue(1'b0, 32'h10, 32'h0);
    cmd_valid = 1'b0;
    @(negedge CLK);
    #3;
    checks++;
    if ({PSEL, PENABLE} !== 2'b11) begin
      failures++; $display("FAIL reset_pre_access psel/pen got=%b%b want=11", PSEL, PENABLE);
    end
    nRST = 1'b0;
    #1;
    checks++;
    if ({PSEL, PENABLE, PWRITE, PADDR, PWDATA, rsp_valid, cmd_ready} !== '0) begin
      failures++;
      $display("FAIL reset_mid_access psel=%b pen=%b paddr=%h rsp_v=%b ready=%b want all 0",
               PSEL, PENABLE, PADDR, rsp_valid, cmd_ready);
    end
    @(negedge CLK); @(negedge CLK);
    nRST = 1'b1;
    n_wait = 0;
    #3;
    checks++;
    if (cmd_ready !== 1'b1) begin
      failures++; $display("FAIL reset_mid_release_ready got=%b want=1", cmd_ready);
    end
    repeat (10) @(negedge CLK);
    #3;
    checks++;
    if (act_q.size() != 0) begin
      failures++; $display("FAIL reset_no_rsp got=%0d responses want=0", act_q.size());
      act_q.delete();
    end
  endtask

  task automatic test_write_read();
    rsp_t e, a;
    @(negedge CLK);
    issue(1'b1, 32'h0000_0004, 32'hDEAD_BEEF);
    push_exp(32'h0, 1'b0, 1'b0, 3);
    cmd_valid = 1'b0;
    #3;
    checks++;
    if ({PSEL, PENABLE, PWRITE, PADDR, PWDATA} !== {3'b101, 32'h4, 32'hDEAD_BEEF}) begin
      failures++;
      $display("FAIL wr_setup psel=%b pen=%b pwrite=%b paddr=%h pwdata=%h want 1 0 1 00000004 deadbeef",
               PSEL, PENABLE, PWRITE, PADDR, PWDATA);
    end
    @(negedge CLK); #3;
    checks++;
    if ({PSEL, PENABLE, PWDATA} !== {2'b11, 32'hDEAD_BEEF}) begin
      failures++; $display("FAIL wr_access psel=%b pen=%b pwdata=%h want 1 1 deadbeef", PSEL, PENABLE, PWDATA);
    end
    @(negedge CLK); #3;
    checks++;
    if ({PSEL, rsp_valid} !== 2'b01) begin
      failures++; $display("FAIL wr_done psel=%b rsp_valid=%b want 0 1", PSEL, rsp_valid);
    end
    @(negedge CLK);
    issue(1'b0, 32'h0000_0004, 32'hFFFF_FFFF);
    push_exp(32'hDEAD_BEEF, 1'b0, 1'b0, 3);
    cmd_valid = 1'b0;
    #3;
    checks++;
    if ({PWRITE, PWDATA} !== 33'h0) begin
      failures++; $display("FAIL rd_wdata_zero pwrite=%b pwdata=%h want 0 00000000", PWRITE, PWDATA);
    end
    wait_rsp(2);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      checks++;
      if (act_q.size() == 0) begin
        failures++; $display("FAIL wr_rd_rsp missing response");
      end else begin
        a = act_q.pop_front();
        if ({a.rdata, a.err, a.tmo, a.lat} !== {e.rdata, e.err, e.tmo, e.lat}) begin
          failures++;
          $display("FAIL wr_rd_rsp got rdata=%h err=%b tmo=%b lat=%0d want rdata=%h err=%b tmo=%b lat=%0d",
                   a.rdata, a.err, a.tmo, a.lat, e.rdata, e.err, e.tmo, e.lat);
        end
      end
    end
  endtask

  task automatic test_wait_states();
    rsp_t e, a;
    int   psel_n = 0;
    int   unstable = 0;
    @(negedge CLK);
    n_wait = 3;
    issue(1'b0, 32'h0000_0004, 32'h0);
    push_exp(32'hDEAD_BEEF, 1'b0, 1'b0, 6);
    cmd_valid = 1'b0;
    for (int i = 0; i < 10; i++) begin
      #3;
      if (PSEL) begin
        psel_n++;
        if (PADDR !== 32'h4 || PWRITE !== 1'b0) unstable++;
      end
      @(negedge CLK);
    end
    n_wait = 0;
    checks++;
    if (psel_n != 5 || unstable != 0) begin
      failures++; $display("FAIL wait_psel_cycles got=%0d unstable=%0d want 5 0", psel_n, unstable);
    end
    wait_rsp(1);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      checks++;
      if (act_q.size() == 0) begin
        failures++; $display("FAIL wait_rsp missing response");
      end else begin
        a = act_q.pop_front();
        if ({a.rdata, a.err, a.tmo, a.lat} !== {e.rdata, e.err, e.tmo, e.lat}) begin
          failures++;
          $display("FAIL wait_rsp got rdata=%h err=%b tmo=%b lat=%0d want rdata=%h err=%b tmo=%b lat=%0d",
                   a.rdata, a.err, a.tmo, a.lat, e.rdata, e.err, e.tmo, e.lat);
        end
      end
    end
    checks++;
    if (act_q.size() != 0) begin
      failures++; $display("FAIL wait_single_rsp extra=%0d want 0", act_q.size());
      act_q.delete();
    end
  endtask

  task automatic test_back_to_back();
    rsp_t e, a;
    int   prev = -1;
    @(negedge CLK);
    psel_gap = 0;
    for (int k = 0; k < 4; k++) begin
      issue(1'b1, 32'h8 + 32'(4 * k), 32'hA5A5_0000 + 32'(k));
      push_exp(32'h0, 1'b0, 1'b0, 3);
      bb_mon = 1;
    end
    cmd_valid = 1'b0;
    @(negedge CLK); #3;
    bb_mon = 0;
    checks++;
    if (psel_gap != 0) begin
      failures++; $display("FAIL b2b_psel_gap got=%0d low cycles want 0", psel_gap);
    end
    wait_rsp(4);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      checks++;
      if (act_q.size() == 0) begin
        failures++; $display("FAIL b2b_rsp missing response");
      end else begin
        a = act_q.pop_front();
        if ({a.rdata, a.err, a.tmo, a.lat} !== {e.rdata, e.err, e.tmo, e.lat} ||
            (prev >= 0 && a.cyc - prev != 2)) begin
          failures++;
          $display("FAIL b2b_rsp got rdata=%h err=%b lat=%0d gap=%0d want rdata=%h err=%b lat=%0d gap=2",
                   a.rdata, a.err, a.lat, a.cyc - prev, e.rdata, e.err, e.lat);
        end
        prev = a.cyc;
      end
    end
    @(negedge CLK);
    issue(1'b0, 32'h10, 32'h0);
    push_exp(32'hA5A5_0002, 1'b0, 1'b0, 3);
    cmd_valid = 1'b0;
    wait_rsp(1);
    e = exp_q.pop_front();
    checks++;
    if (act_q.size() == 0) begin
      failures++; $display("FAIL b2b_readback missing response");
    end else begin
      a = act_q.pop_front();
      if ({a.rdata, a.err, a.tmo, a.lat} !== {e.rdata, e.err, e.tmo, e.lat}) begin
        failures++;
        $display("FAIL b2b_readback got rdata=%h lat=%0d want rdata=%h lat=%0d", a.rdata, a.lat, e.rdata, e.lat);
      end
    end
  endtask

  task automatic test_slverr();
    rsp_t e, a;
    @(negedge CLK);
    err_cfg = 1;
    issue(1'b0, 32'h4, 32'h0);
    push_exp(32'hDEAD_BEEF, 1'b1, 1'b0, 3);
    cmd_valid = 1'b0;
    wait_rsp(1);
    err_cfg = 0;
    // PSLVERR high only during wait cycles must not reach rsp_err.
    err_on_wait = 1;
    n_wait = 2;
    @(negedge CLK);
    issue(1'b0, 32'h4, 32'h0);
    push_exp(32'hDEAD_BEEF, 1'b0, 1'b0, 5);
    cmd_valid = 1'b0;
    wait_rsp(2);
    err_on_wait = 0;
    n_wait = 0;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      checks++;
      if (act_q.size() == 0) begin
        failures++; $display("FAIL slverr_rsp missing response");
      end else begin
        a = act_q.pop_front();
        if ({a.rdata, a.err, a.tmo, a.lat} !== {e.rdata, e.err, e.tmo, e.lat}) begin
          failures++;
          $display("FAIL slverr_rsp got rdata=%h err=%b tmo=%b lat=%0d want rdata=%h err=%b tmo=%b lat=%0d",
                   a.rdata, a.err, a.tmo, a.lat, e.rdata, e.err, e.tmo, e.lat);
        end
      end
    end
  endtask

  task automatic test_timeout();
    rsp_t e, a;
    int   acc_n = 0;
    bit   seen = 0;
    @(negedge CLK);
    n_wait = 1000;
    issue(1'b0, 32'h4, 32'h0);
    push_exp(32'h0, 1'b1, 1'b1, 18);
    cmd_valid = 1'b0;
    for (int i = 0; i < 40 && !seen; i++) begin
      #3;
      if (rsp_valid) begin
        seen = 1;
        checks++;
        if (PSEL !== 1'b0 || cmd_ready !== 1'b1) begin
          failures++; $display("FAIL tmo_bus_idle psel=%b cmd_ready=%b want 0 1", PSEL, cmd_ready);
        end
      end else begin
        if (PSEL && PENABLE) acc_n++;
        @(negedge CLK);
      end
    end
    checks++;
    if (acc_n != 16) begin
      failures++; $display("FAIL tmo_access_cycles got=%0d want=16", acc_n);
    end
    wait_rsp(1);
    e = exp_q.pop_front();
    checks++;
    if (act_q.size() == 0) begin
      failures++; $display("FAIL tmo_rsp missing response");
    end else begin
      a = act_q.pop_front();
      if ({a.rdata, a.err, a.tmo, a.lat} !== {e.rdata, e.err, e.tmo, e.lat}) begin
        failures++;
        $display("FAIL tmo_rsp got rdata=%h err=%b tmo=%b lat=%0d want rdata=%h err=%b tmo=%b lat=%0d",
                 a.rdata, a.err, a.tmo, a.lat, e.rdata, e.err, e.tmo, e.lat);
      end
    end
    @(negedge CLK); #3;
    checks++;
    if ({rsp_valid, rsp_err, rsp_timeout, rsp_rdata} !== {3'b011, 32'h0}) begin
      failures++;
      $display("FAIL tmo_hold valid=%b err=%b tmo=%b rdata=%h want 0 1 1 00000000",
               rsp_valid, rsp_err, rsp_timeout, rsp_rdata);
    end
    n_wait = 0;
  endtask

  task automatic test_no_timeout();
    int  acc_n = 0;
    int  rsp_n = 0;
    bit  rdy;
    @(negedge CLK);
    cmd_write = 1'b1; cmd_addr = 32'h0000_0040; cmd_wdata = 32'hCAFE_F00D;
    cmd_valid_nt = 1'b1;
    #3;
    rdy = cmd_ready_nt;
    @(negedge CLK);
    cmd_valid_nt = 1'b0;
    checks++;
    if (rdy !== 1'b1) begin
      failures++; $display("FAIL nt_accept cmd_ready=%b want 1", rdy);
    end
    for (int i = 0; i < 102; i++) begin
      #3;
      if (psel_nt && penable_nt) acc_n++;
      if (rsp_valid_nt) rsp_n++;
      @(negedge CLK);
    end
    checks++;
    if (acc_n != 101 || rsp_n != 0) begin
      failures++; $display("FAIL nt_no_abort access=%0d rsp=%0d want 101 0", acc_n, rsp_n);
    end
    checks++;
    if ({pwrite_nt, paddr_nt, pwdata_nt, rsp_err_nt, rsp_timeout_nt, rsp_rdata_nt} !==
        {1'b1, 32'h40, 32'hCAFE_F00D, 2'b00, 32'h0}) begin
      failures++;
      $display("FAIL nt_bus_hold pwrite=%b paddr=%h pwdata=%h err=%b tmo=%b want 1 00000040 cafef00d 0 0",
               pwrite_nt, paddr_nt, pwdata_nt, rsp_err_nt, rsp_timeout_nt);
    end
  endtask

  initial begin
    nRST = 1'b0;
    cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = '0; cmd_wdata = '0;
    cmd_valid_nt = 1'b0;
    for (int i = 0; i < 16; i++) mem[i] = '0;
    test_reset();
    test_write_read();
    test_wait_states();
    test_back_to_back();
    test_slverr();
    test_timeout();
    test_no_timeout();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
